dram_timing_ctrl: RTL and testbench

DRAM_TIMING_CTRL -- requirements
Module: dram_timing_ctrl

---
 rtl/dram_timing_ctrl_pkg.sv | 28 ++
 rtl/dram_timing_ctrl_cycle_counter.sv | 30 +++
 rtl/dram_timing_ctrl.sv | 144 ++++++++++++++
 tb/tb_dram_timing_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dram_timing_ctrl_pkg.sv
// Shared definitions for the DRAM timing controller family: state encoding,
// default timing constants and the delay-counter width helper.
package dram_timing_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ROW       = 3'd1,
    ST_COL       = 3'd2,
    ST_CAS       = 3'd3,
    ST_RFSH      = 3'd4,
    ST_PRECHARGE = 3'd5
  } state_t;

  localparam int DEFAULT_NUM_BANKS  = 2;
  localparam int DEFAULT_RAS_TO_MUX = 1;
  localparam int DEFAULT_MUX_TO_CAS = 1;
  localparam int DEFAULT_T_RP       = 2;

  // Wide enough to hold the largest phase delay; loads are delay-1 so this has slack.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dram_timing_ctrl_cycle_counter.sv
// Down-counter shared by all controller phases: loaded with (delay - 1),
// saturates at zero and flags terminal count while it sits there.
module cycle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/dram_timing_ctrl.sv
// Z80-style DRAM timing controller: RAS/MUX/CAS sequencing per bank,
// RAS-only refresh and a fixed precharge window, all outputs registered.
module dram_timing_ctrl
  import dram_timing_ctrl_pkg::*;
#(
  parameter int NUM_BANKS  = DEFAULT_NUM_BANKS,
  parameter int RAS_TO_MUX = DEFAULT_RAS_TO_MUX,
  parameter int MUX_TO_CAS = DEFAULT_MUX_TO_CAS,
  parameter int T_RP       = DEFAULT_T_RP
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 nmreq,
  input  logic                 nrfshd,
  input  logic                 nrd,
  input  logic                 nwr,
  input  logic [NUM_BANKS-1:0] nsel,
  output logic [NUM_BANKS-1:0] nras,
  output logic                 mux,
  output logic                 ncas,
  output logic                 nwe,
  output logic                 busy
);

  localparam int CNT_W  = cnt_width(RAS_TO_MUX, MUX_TO_CAS, T_RP);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  state_t               state, state_nxt;
  logic [BANK_W-1:0]    bank, bank_nxt, sel_idx;
  logic                 sel_any;
  logic [NUM_BANKS-1:0] nras_nxt;
  logic                 mux_nxt, ncas_nxt, nwe_nxt;
  logic                 cnt_load, cnt_done;
  logic [CNT_W-1:0]     cnt_load_val;

  cycle_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .nreset   (nreset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .enable   (busy),
    .done     (cnt_done)
  );

  // Lowest-index asserted select wins when several slots are selected at once.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!nsel[i]) sel_idx = BANK_W'(i);
    end
    sel_any = ~&nsel;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    bank_nxt     = bank;
    nwe_nxt      = nwe;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    case (state)
      ST_IDLE: begin
        if (!nmreq) begin
          if (!nrfshd) begin
            state_nxt = ST_RFSH;
          end else if (sel_any) begin
            state_nxt    = ST_ROW;
            bank_nxt     = sel_idx;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(RAS_TO_MUX - 1);
          end
        end
      end
      ST_ROW: begin
        if (nmreq) begin
          state_nxt    = ST_PRECHARGE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_RP - 1);
        end else if (cnt_done) begin
          state_nxt    = ST_COL;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(MUX_TO_CAS - 1);
        end
      end
      ST_COL: begin
        if (nmreq) begin
          state_nxt    = ST_PRECHARGE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_RP - 1);
        end else if (cnt_done && (!nrd || !nwr)) begin
          state_nxt = ST_CAS;
          nwe_nxt   = nwr;
        end
      end
      ST_CAS, ST_RFSH: begin
        if (nmreq) begin
          state_nxt    = ST_PRECHARGE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(T_RP - 1);
        end
      end
      ST_PRECHARGE: begin
        if (cnt_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Output decode from the next state keeps every strobe a clean flop output.
    nras_nxt = '1;
    if (state_nxt == ST_RFSH) begin
      nras_nxt = '0;
    end else if (state_nxt inside {ST_ROW, ST_COL, ST_CAS}) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (BANK_W'(i) == bank_nxt) nras_nxt[i] = 1'b0;
      end
    end
    mux_nxt  = (state_nxt == ST_COL) || (state_nxt == ST_CAS);
    ncas_nxt = (state_nxt != ST_CAS);
    if (state_nxt != ST_CAS) nwe_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= ST_IDLE;
      bank  <= '0;
      nras  <= '1;
      mux   <= 1'b0;
      ncas  <= 1'b1;
      nwe   <= 1'b1;
    end else begin
      state <= state_nxt;
      bank  <= bank_nxt;
      nras  <= nras_nxt;
      mux   <= mux_nxt;
      ncas  <= ncas_nxt;
      nwe   <= nwe_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Self-checking bench for dram_timing_ctrl (4 banks, 1/1/2 timing): a cycle
// vector table fed through a scoreboard queue, plus bounded latency sequences.
module tb_dram_timing_ctrl;

  typedef struct packed {
    logic       rst;
    logic       mreq;
    logic       rfsh;
    logic       rd;
    logic       wr;
    logic [3:0] sel;
  } in_t;

  typedef struct packed {
    logic [3:0] nras;
    logic       mux;
    logic       ncas;
    logic       nwe;
    logic       busy;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       nmreq = 1'b1, nrfshd = 1'b1, nrd = 1'b1, nwr = 1'b1;
  logic [3:0] nsel = 4'hf;
  logic [3:0] nras;
  logic       mux, ncas, nwe, busy;

  vec_t  vecs[$];
  out_t  sb_exp[$];
  string sb_name[$];
  int    n_vec = 0;
  int    n_err = 0;

  dram_timing_ctrl #(
    .NUM_BANKS (4),
    .RAS_TO_MUX(1),
    .MUX_TO_CAS(1),
    .T_RP      (2)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .nmreq  (nmreq),
    .nrfshd (nrfshd),
    .nrd    (nrd),
    .nwr    (nwr),
    .nsel   (nsel),
    .nras   (nras),
    .mux    (mux),
    .ncas   (ncas),
    .nwe    (nwe),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic mreq, input logic rfsh,
                     input logic rd, input logic wr, input logic [3:0] sel,
                     input logic [3:0] e_nras, input logic e_mux, input logic e_ncas,
                     input logic e_nwe, input logic e_busy);
    vec_t v;
    v.name = name;
    v.i    = {rst, mreq, rfsh, rd, wr, sel};
    v.o    = {e_nras, e_mux, e_ncas, e_nwe, e_busy};
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    nreset = i.rst;
    nmreq  = i.mreq;
    nrfshd = i.rfsh;
    nrd    = i.rd;
    nwr    = i.wr;
    nsel   = i.sel;
  endtask

  function automatic out_t sample();
    return {nras, mux, ncas, nwe, busy};
  endfunction

  initial begin
    out_t got, exp;
    string nm;
    int cyc;

    // name            rst mreq rfsh rd wr sel     nras   mux ncas nwe busy
    add("reset0",       0, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    add("reset1",       0, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    add("idle",         1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    // read to bank 2
    add("rd_row",       1, 0, 1, 0, 1, 4'hb,   4'hb, 0, 1, 1, 1);
    add("rd_col",       1, 0, 1, 0, 1, 4'hb,   4'hb, 1, 1, 1, 1);
    add("rd_cas",       1, 0, 1, 0, 1, 4'hb,   4'hb, 1, 0, 1, 1);
    add("rd_hold3",     1, 0, 1, 0, 1, 4'hb,   4'hb, 1, 0, 1, 1);
    add("rd_hold4",     1, 0, 1, 0, 1, 4'hb,   4'hb, 1, 0, 1, 1);
    add("rd_end",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    // write request held through precharge must wait for IDLE
    add("wr_pre1",      1, 0, 1, 1, 0, 4'he,   4'hf, 0, 1, 1, 1);
    add("wr_pre2",      1, 0, 1, 1, 0, 4'he,   4'hf, 0, 1, 1, 0);
    add("wr_row",       1, 0, 1, 1, 0, 4'he,   4'he, 0, 1, 1, 1);
    add("wr_col",       1, 0, 1, 1, 0, 4'he,   4'he, 1, 1, 1, 1);
    add("wr_cas",       1, 0, 1, 1, 0, 4'he,   4'he, 1, 0, 0, 1);
    add("wr_nwr_drop",  1, 0, 1, 1, 1, 4'h7,   4'he, 1, 0, 0, 1);
    add("wr_end",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("wr_pre",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("wr_idle",      1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    // refresh wins over a simultaneous select
    add("rf_enter",     1, 0, 0, 1, 1, 4'hd,   4'h0, 0, 1, 1, 1);
    add("rf_hold1",     1, 0, 1, 1, 1, 4'hd,   4'h0, 0, 1, 1, 1);
    add("rf_hold2",     1, 0, 1, 0, 1, 4'hd,   4'h0, 0, 1, 1, 1);
    add("rf_end",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("rf_pre",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("rf_idle",      1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    // memory request with no slot selected is ignored
    add("nosel0",       1, 0, 1, 0, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    add("nosel1",       1, 0, 1, 0, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    // contention picks bank 0, then abort in ROW
    add("ct_row",       1, 0, 1, 1, 1, 4'h6,   4'he, 0, 1, 1, 1);
    add("ct_abort",     1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("ct_pre",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("ct_idle",      1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);
    // COL waits for a strobe, then reset mid-CAS with request held
    add("cw_row",       1, 0, 1, 1, 1, 4'hd,   4'hd, 0, 1, 1, 1);
    add("cw_col",       1, 0, 1, 1, 1, 4'hd,   4'hd, 1, 1, 1, 1);
    add("cw_wait",      1, 0, 1, 1, 1, 4'hd,   4'hd, 1, 1, 1, 1);
    add("cw_cas",       1, 0, 1, 0, 1, 4'hd,   4'hd, 1, 0, 1, 1);
    add("rs_mid",       0, 0, 1, 0, 1, 4'hd,   4'hf, 0, 1, 1, 0);
    add("rs_release",   1, 0, 1, 0, 1, 4'hd,   4'hd, 0, 1, 1, 1);
    add("rs_col",       1, 0, 1, 0, 1, 4'hd,   4'hd, 1, 1, 1, 1);
    add("rs_cas",       1, 0, 1, 0, 1, 4'hd,   4'hd, 1, 0, 1, 1);
    add("rs_end",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("rs_pre",       1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 1);
    add("rs_idle",      1, 1, 1, 1, 1, 4'hf,   4'hf, 0, 1, 1, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      sb_exp.push_back(vecs[k].o);
      sb_name.push_back(vecs[k].name);
      @(posedge clk);
      #1;
      exp = sb_exp.pop_front();
      nm  = sb_name.pop_front();
      got = sample();
      check(nm, 32'(got), 32'(exp));
    end

    // Bank 3 read: edges from request until ncas falls, bounded.
    @(negedge clk);
    drive({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7});
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
    end while (ncas !== 1'b0 && cyc < 10);
    check("seq_cas_latency", 32'(cyc), 32'd3);
    check("seq_bank3_nras", 32'(nras), 32'h7);

    // Release nmreq: edges until busy drops covers F plus T_RP.
    drive({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hf});
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
    end while (busy !== 1'b0 && cyc < 10);
    check("seq_release_to_idle", 32'(cyc), 32'd3);
    check("seq_idle_outputs", 32'(sample()), 32'({4'hf, 1'b0, 1'b1, 1'b1, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
